// File: rtl/multicycle_mainfsm_if.sv
// Control bundle between the multicycle main FSM and its datapath: opcode and
// zero flag in, strobes and selects out.
interface multicycle_mainfsm_if;
    logic [6:0] op;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       illegal_instr;

    // The FSM side drives the control signals.
    modport master (
        input  op, Zero,
        output PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr
    );

    // The datapath side supplies the opcode and the ALU zero flag.
    modport slave (
        output op, Zero,
        input  PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr
    );
endinterface

// File: rtl/multicycle_mainfsm.sv
// Main control FSM of a multicycle RV32 subset (lw, sw, R, I, jal, beq).
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky ILLEGAL state.
module multicycle_mainfsm (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_mainfsm_if.master  ctrl
);

    typedef enum logic [3:0] {
        S0_FETCH    = 4'd0,
        S1_DECODE   = 4'd1,
        S2_MEMADR   = 4'd2,
        S3_MEMREAD  = 4'd3,
        S4_MEMWB    = 4'd4,
        S5_MEMWRITE = 4'd5,
        S6_EXECR    = 4'd6,
        S7_ALUWB    = 4'd7,
        S8_EXECI    = 4'd8,
        S9_JAL      = 4'd9,
        S10_BEQ     = 4'd10,
        S_ILLEGAL   = 4'd11
    } state_t;

    localparam int NUM_OPS = 6;
    localparam int HIT_LW  = 0;
    localparam int HIT_SW  = 1;
    localparam int HIT_R   = 2;
    localparam int HIT_I   = 3;
    localparam int HIT_JAL = 4;
    localparam int HIT_BEQ = 5;

    localparam logic [6:0] OPCODES [NUM_OPS] = '{
        7'b0000011,   // lw
        7'b0100011,   // sw
        7'b0110011,   // R-type
        7'b0010011,   // I-type ALU
        7'b1101111,   // jal
        7'b1100011    // beq
    };

    state_t             state_reg;
    state_t             state_next;
    logic [NUM_OPS-1:0] op_hit;

    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       pc_update;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;

    // One comparator per supported opcode; decode and ImmSrc both use these hits.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_hit
            assign op_hit[gi] = (ctrl.op == OPCODES[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S0_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S0_FETCH: begin
                state_next = S1_DECODE;
            end
            S1_DECODE: begin
                if (op_hit[HIT_LW] || op_hit[HIT_SW]) begin
                    state_next = S2_MEMADR;
                end else if (op_hit[HIT_R]) begin
                    state_next = S6_EXECR;
                end else if (op_hit[HIT_I]) begin
                    state_next = S8_EXECI;
                end else if (op_hit[HIT_JAL]) begin
                    state_next = S9_JAL;
                end else if (op_hit[HIT_BEQ]) begin
                    state_next = S10_BEQ;
                end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    state_next = S_ILLEGAL;
`else
                    state_next = S0_FETCH;
`endif
                end
            end
            S2_MEMADR: begin
                state_next = op_hit[HIT_LW] ? S3_MEMREAD : S5_MEMWRITE;
            end
            S3_MEMREAD:  state_next = S4_MEMWB;
            S4_MEMWB:    state_next = S0_FETCH;
            S5_MEMWRITE: state_next = S0_FETCH;
            S6_EXECR:    state_next = S7_ALUWB;
            S7_ALUWB:    state_next = S0_FETCH;
            S8_EXECI:    state_next = S7_ALUWB;
            S9_JAL:      state_next = S7_ALUWB;
            S10_BEQ:     state_next = S0_FETCH;
            S_ILLEGAL: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                state_next = S_ILLEGAL;
`else
                state_next = S0_FETCH;
`endif
            end
            default: begin
                state_next = S0_FETCH;
            end
        endcase
    end

    always_comb begin
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        unique case (state_reg)
            S0_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S1_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S2_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S3_MEMREAD: begin
                adr_src = 1'b1;
            end
            S4_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S5_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S6_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S7_ALUWB: begin
                reg_write = 1'b1;
            end
            S8_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S9_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S10_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: begin
                // ILLEGAL and unused encodings keep every strobe low.
            end
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        if (op_hit[HIT_SW]) begin
            imm_src = 2'b01;
        end else if (op_hit[HIT_BEQ]) begin
            imm_src = 2'b10;
        end else if (op_hit[HIT_JAL]) begin
            imm_src = 2'b11;
        end
    end

    // Reset holds the state in Fetch; its PC and IR loads are masked so nothing updates.
    assign ctrl.PCWrite   = reset & (pc_update | (branch & ctrl.Zero));
    assign ctrl.IRWrite   = reset & ir_write;
    assign ctrl.AdrSrc    = adr_src;
    assign ctrl.RegWrite  = reg_write;
    assign ctrl.MemWrite  = mem_write;
    assign ctrl.ResultSrc = result_src;
    assign ctrl.ALUSrcA   = alu_src_a;
    assign ctrl.ALUSrcB   = alu_src_b;
    assign ctrl.ALUOp     = alu_op;
    assign ctrl.ImmSrc    = imm_src;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_reg <= 1'b0;
        end else if (state_next == S_ILLEGAL) begin
            illegal_reg <= 1'b1;
        end
    end

    assign ctrl.illegal_instr = illegal_reg;
`else
    assign ctrl.illegal_instr = 1'b0;
`endif

endmodule
